// File: rtl/muldiv_sequencer_pkg.sv
// Shared definitions for the RV32M multiply/divide sequencer: ALU control
// encodings, FSM state type and the iteration datapath mode.
package muldiv_sequencer_pkg;

  localparam int XLEN  = 32;
  localparam int CNT_W = 6;

  localparam logic [XLEN-1:0] SIGNED_MIN = {1'b1, {(XLEN-1){1'b0}}};

  localparam logic [4:0] ALU_ADD    = 5'b00000;
  localparam logic [4:0] ALU_SUB    = 5'b00001;
  localparam logic [4:0] ALU_MUL    = 5'b00010;
  localparam logic [4:0] ALU_MULH   = 5'b00011;
  localparam logic [4:0] ALU_MULHSU = 5'b00100;
  localparam logic [4:0] ALU_MULHU  = 5'b00101;
  localparam logic [4:0] ALU_DIV    = 5'b00110;
  localparam logic [4:0] ALU_DIVU   = 5'b00111;
  localparam logic [4:0] ALU_REM    = 5'b01000;
  localparam logic [4:0] ALU_REMU   = 5'b01001;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } state_e;

  typedef enum logic {
    MODE_MUL,
    MODE_DIV
  } step_mode_e;

  // True for the contiguous block of M-extension codes (mul..remu).
  function automatic logic is_m_op(input logic [4:0] code);
    return (code >= ALU_MUL) && (code <= ALU_REMU);
  endfunction

endpackage

// File: rtl/muldiv_sequencer_step.sv
// One iteration of the shift-add multiplier or restoring divider.
// Multiply: acc = {partial_hi, multiplier_lo}, operand = multiplicand.
// Divide:   acc = {remainder, dividend/quotient}, operand = divisor.
module muldiv_sequencer_step
  import muldiv_sequencer_pkg::*;
(
  input  step_mode_e            i_mode,
  input  logic [2*XLEN-1:0]     i_acc,
  input  logic [XLEN-1:0]       i_operand,
  output logic [2*XLEN-1:0]     o_acc
);

  logic [XLEN:0]   w_sum;
  logic [XLEN:0]   w_shift;
  logic [XLEN-1:0] w_diff;
  logic            w_ge;

  // Single combinational step; the remainder always stays below the divisor,
  // so a 32-bit difference is exact whenever the trial subtract succeeds.
  always_comb begin
    w_sum   = {1'b0, i_acc[2*XLEN-1:XLEN]} + {1'b0, i_operand};
    w_shift = i_acc[2*XLEN-1:XLEN-1];
    w_ge    = (w_shift >= {1'b0, i_operand});
    w_diff  = w_shift[XLEN-1:0] - i_operand;
    o_acc   = '0;
    if (i_mode == MODE_MUL) begin
      if (i_acc[0]) begin
        o_acc = {w_sum, i_acc[XLEN-1:1]};
      end else begin
        o_acc = {1'b0, i_acc[2*XLEN-1:1]};
      end
    end else begin
      if (w_ge) begin
        o_acc = {w_diff, i_acc[XLEN-2:0], 1'b1};
      end else begin
        o_acc = {w_shift[XLEN-1:0], i_acc[XLEN-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// RV32M multi-cycle sequencer beside the execute-stage ALU.
//   state  | meaning
//   S_IDLE | waiting for an M op; in_ready high
//   S_CALC | 32 shift-add / restoring-divide iterations on magnitudes
//   S_FIX  | sign correction and result-word selection
//   S_DONE | result presented until consumed
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_flush,
  input  logic            i_in_valid,
  output logic            o_in_ready,
  input  logic [4:0]      i_alu_ctl,
  input  logic [XLEN-1:0] i_op_a,
  input  logic [XLEN-1:0] i_op_b,
  output logic            o_out_valid,
  input  logic            i_out_ready,
  output logic [XLEN-1:0] o_result,
  output logic            o_busy
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

  state_e            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [2*XLEN-1:0] r_acc;
  logic [XLEN-1:0]   r_opnd;
  logic [4:0]        r_op;
  logic              r_neg_res;
  logic [XLEN-1:0]   r_result;
  logic              r_out_valid;
  logic              r_busy;
  logic              r_in_ready;

  logic              w_accept;
  logic              w_in_div;
  logic              w_in_rem;
  logic              w_in_sdiv;
  logic              w_sign_a;
  logic              w_sign_b;
  logic [XLEN-1:0]   w_mag_a;
  logic [XLEN-1:0]   w_mag_b;
  logic              w_div_zero;
  logic              w_div_ovf;
  logic [XLEN-1:0]   w_special_res;
  step_mode_e        w_mode;
  logic [2*XLEN-1:0] w_step_acc;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_quo;
  logic [XLEN-1:0]   w_rem;
  logic [XLEN-1:0]   w_fix_sel;

  // Decode of the incoming request: sign flags, magnitudes, special cases.
  always_comb begin
    w_accept   = (r_state == S_IDLE) && i_in_valid && !i_flush && is_m_op(i_alu_ctl);
    w_in_div   = (i_alu_ctl == ALU_DIV) || (i_alu_ctl == ALU_DIVU) ||
                 (i_alu_ctl == ALU_REM) || (i_alu_ctl == ALU_REMU);
    w_in_rem   = (i_alu_ctl == ALU_REM) || (i_alu_ctl == ALU_REMU);
    w_in_sdiv  = (i_alu_ctl == ALU_DIV) || (i_alu_ctl == ALU_REM);
    w_sign_a   = i_op_a[XLEN-1] &&
                 ((i_alu_ctl == ALU_MUL) || (i_alu_ctl == ALU_MULH) ||
                  (i_alu_ctl == ALU_MULHSU) || w_in_sdiv);
    w_sign_b   = i_op_b[XLEN-1] &&
                 ((i_alu_ctl == ALU_MUL) || (i_alu_ctl == ALU_MULH) || w_in_sdiv);
    w_mag_a    = w_sign_a ? (XLEN'(0) - i_op_a) : i_op_a;
    w_mag_b    = w_sign_b ? (XLEN'(0) - i_op_b) : i_op_b;
    w_div_zero = w_in_div && (i_op_b == '0);
    w_div_ovf  = w_in_sdiv && (i_op_a == SIGNED_MIN) && (i_op_b == '1);
    if (w_div_zero) begin
      w_special_res = w_in_rem ? i_op_a : '1;
    end else begin
      w_special_res = w_in_rem ? '0 : SIGNED_MIN;
    end
  end

  // Sign fix on the finished accumulator and selection of the wanted word.
  always_comb begin
    w_mode = (r_op >= ALU_DIV) ? MODE_DIV : MODE_MUL;
    w_prod = r_neg_res ? ((2*XLEN)'(0) - r_acc) : r_acc;
    w_quo  = r_neg_res ? (XLEN'(0) - r_acc[XLEN-1:0]) : r_acc[XLEN-1:0];
    w_rem  = r_neg_res ? (XLEN'(0) - r_acc[2*XLEN-1:XLEN]) : r_acc[2*XLEN-1:XLEN];
    case (r_op)
      ALU_MUL:                          w_fix_sel = w_prod[XLEN-1:0];
      ALU_MULH, ALU_MULHSU, ALU_MULHU:  w_fix_sel = w_prod[2*XLEN-1:XLEN];
      ALU_DIV, ALU_DIVU:                w_fix_sel = w_quo;
      default:                          w_fix_sel = w_rem;
    endcase
  end

  muldiv_sequencer_step u_step (
    .i_mode    (w_mode),
    .i_acc     (r_acc),
    .i_operand (r_opnd),
    .o_acc     (w_step_acc)
  );

  // Control FSM with registered handshake outputs; flush overrides everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_acc       <= '0;
      r_opnd      <= '0;
      r_op        <= '0;
      r_neg_res   <= 1'b0;
      r_result    <= '0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_in_ready  <= 1'b1;
    end else if (i_flush) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_in_ready  <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op       <= i_alu_ctl;
            r_neg_res  <= w_in_rem ? w_sign_a : (w_sign_a ^ w_sign_b);
            r_busy     <= 1'b1;
            r_in_ready <= 1'b0;
            if (w_div_zero || w_div_ovf) begin
              r_result    <= w_special_res;
              r_out_valid <= 1'b1;
              r_state     <= S_DONE;
            end else begin
              // Multiplier sits in the low half; dividend shifts out of it.
              r_acc   <= {{XLEN{1'b0}}, w_in_div ? w_mag_a : w_mag_b};
              r_opnd  <= w_in_div ? w_mag_b : w_mag_a;
              r_cnt   <= '0;
              r_state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          r_acc <= w_step_acc;
          if (r_cnt == CNT_LAST) begin
            r_cnt   <= '0;
            r_state <= S_FIX;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_FIX: begin
          r_result    <= w_fix_sel;
          r_out_valid <= 1'b1;
          r_state     <= S_DONE;
        end
        S_DONE: begin
          if (i_out_ready) begin
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_in_ready  = r_in_ready;
  assign o_out_valid = r_out_valid;
  assign o_result    = r_result;
  assign o_busy      = r_busy;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed plus random checks of muldiv_sequencer against an arithmetic
// reference model of the RV32M operations.
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  alu_ctl;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  muldiv_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_flush     (flush),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .i_alu_ctl   (alu_ctl),
    .i_op_a      (op_a),
    .i_op_b      (op_b),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_result    (result),
    .o_busy      (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Architectural result of an RV32M op, from plain 64-bit arithmetic.
  function automatic logic [31:0] ref_model(input logic [4:0] c, input logic [31:0] a,
                                            input logic [31:0] b);
    longint    sa = longint'($signed(a));
    longint    sb = longint'($signed(b));
    logic [63:0] ua = {32'b0, a};
    logic [63:0] ub = {32'b0, b};
    logic [63:0] p;
    longint    q;
    case (c)
      5'd2: begin p = sa * sb; return p[31:0]; end
      5'd3: begin p = sa * sb; return p[63:32]; end
      5'd4: begin q = sa * longint'(ub); p = q; return p[63:32]; end
      5'd5: begin p = ua * ub; return p[63:32]; end
      5'd6: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        q = sa / sb; return q[31:0];
      end
      5'd7: begin
        if (b == 0) return 32'hFFFF_FFFF;
        p = ua / ub; return p[31:0];
      end
      5'd8: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        q = sa % sb; return q[31:0];
      end
      default: begin
        if (b == 0) return a;
        p = ua % ub; return p[31:0];
      end
    endcase
  endfunction

  task automatic run_op(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b,
                        input int hold, input logic [31:0] exp, input string tag);
    int   edges;
    logic busy_ok;
    bit   special;
    special = ((c >= 5'd6) && (c <= 5'd9) && (b == 0)) ||
              (((c == 5'd6) || (c == 5'd8)) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF));
    chk({tag, ":in_ready"}, 32'(in_ready), 32'd1);
    alu_ctl  = c;
    op_a     = a;
    op_b     = b;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    op_a     = $urandom;
    op_b     = $urandom;
    alu_ctl  = 5'($urandom_range(2, 9));
    edges    = 1;
    busy_ok  = 1'b1;
    while (!out_valid && edges < 60) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      @(posedge clk); #1;
      edges++;
    end
    chk({tag, ":latency"}, 32'(edges), special ? 32'd1 : 32'd34);
    chk({tag, ":busy"}, 32'({busy_ok, busy}), 32'd3);
    chk({tag, ":result"}, result, exp);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      alu_ctl  = 5'b00010;
      op_a     = $urandom;
      @(posedge clk); #1;
      chk({tag, ":hold_flags"}, 32'({out_valid, in_ready, busy}), 32'b101);
      chk({tag, ":hold_result"}, result, exp);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, ":release_flags"}, 32'({out_valid, in_ready, busy}), 32'b010);
    chk({tag, ":idle_result"}, result, exp);
  endtask

  initial begin
    logic [4:0]  c;
    logic [31:0] a;
    logic [31:0] b;
    int          r;
    bit          saw;

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    alu_ctl = '0; op_a = '0; op_b = '0;
    #12;
    chk("reset_flags", 32'({out_valid, in_ready, busy}), 32'b010);
    chk("reset_result", result, 32'h0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(5'b00010, 32'd7, 32'hFFFF_FFFD, 5, 32'hFFFF_FFEB, "mul_7x-3");
    run_op(5'b00011, 32'h8000_0000, 32'h8000_0000, 0, 32'h4000_0000, "mulh_min");
    run_op(5'b00101, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFE, "mulhu_max");
    run_op(5'b00100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 32'hFFFF_FFFF, "mulhsu_max");
    run_op(5'b00110, 32'hFFFF_FFEC, 32'd6, 0, 32'hFFFF_FFFD, "div_-20/6");
    run_op(5'b01000, 32'hFFFF_FFEC, 32'd6, 0, 32'hFFFF_FFFE, "rem_-20/6");
    run_op(5'b00111, 32'd100, 32'd7, 0, 32'd14, "divu_100/7");
    run_op(5'b01001, 32'd100, 32'd7, 0, 32'd2, "remu_100/7");
    run_op(5'b00110, 32'd5, 32'd0, 2, 32'hFFFF_FFFF, "div_by0");
    run_op(5'b01000, 32'd5, 32'd0, 0, 32'd5, "rem_by0");
    run_op(5'b00110, 32'h8000_0000, 32'hFFFF_FFFF, 0, 32'h8000_0000, "div_ovf");
    run_op(5'b01000, 32'h8000_0000, 32'hFFFF_FFFF, 0, 32'h0, "rem_ovf");

    // Non-M codes are ignored.
    for (int k = 0; k < 2; k++) begin
      alu_ctl  = (k == 0) ? 5'b00000 : 5'b01010;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("non_m_ignored", 32'({out_valid, in_ready, busy}), 32'b010);
    end

    // flush together with a request in IDLE blocks the accept.
    alu_ctl = 5'b00010; op_a = 32'd3; op_b = 32'd3;
    flush = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_idle_accept", 32'({out_valid, in_ready, busy}), 32'b010);

    // flush at CALC counter 10.
    alu_ctl = 5'b00010; op_a = 32'd9; op_b = 32'd9; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("pre_flush_busy", 32'({out_valid, busy}), 32'b01);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_calc", 32'({out_valid, in_ready, busy}), 32'b010);
    saw = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) saw = 1'b1;
    end
    chk("flush_no_result", 32'(saw), 32'd0);
    run_op(5'b00010, 32'd3, 32'd4, 0, 32'd12, "post_flush_mul");

    // Asynchronous reset in the middle of CALC.
    alu_ctl = 5'b00111; op_a = 32'd1000; op_b = 32'd3; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_flags", 32'({out_valid, in_ready, busy}), 32'b010);
    chk("async_rst_result", result, 32'h0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Random operations with occasional corner operands.
    for (int n = 0; n < 24; n++) begin
      c = 5'($urandom_range(2, 9));
      a = $urandom;
      b = $urandom;
      r = $urandom_range(0, 7);
      if (r == 0) b = 32'h0;
      if (r == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      if (r == 2) b = 32'($urandom_range(1, 15));
      if (r == 3) a = -32'($urandom_range(1, 1000));
      run_op(c, a, b, $urandom_range(0, 2), ref_model(c, a, b), "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
